// File: rtl/pll_sup_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_sup_pkg
//  Description : Shared state encodings and helpers for the PLL lock
//                supervisor and its synchroniser.
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_sup_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    // Encodings are fixed because STATE is exported for debug readout.
    localparam state_t c_st_pll_rst    = 3'd0;
    localparam state_t c_st_wait_lock  = 3'd1;
    localparam state_t c_st_stable     = 3'd2;
    localparam state_t c_st_run        = 3'd3;
    localparam state_t c_st_fault      = 3'd4;
    localparam state_t c_st_bypass_run = 3'd5;

    // Largest of three counts; sizes the shared phase timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_sup_sync.sv
`default_nettype none
// ============================================================================
//  Module      : pll_sup_sync
//  Description : N-stage single-bit synchroniser, asynchronous active-high
//                reset to 0. STAGES must be at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_sup_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module      : pll_lock_supervisor
//  Description : Sequences PLL_RESETB of an SB_PLL40_CORE-style PLL, filters
//                its asynchronous LOCK through a synchroniser and stability
//                timer, times out and retries failed lock attempts, detects
//                loss of lock in service and drives the PLL-domain reset
//                request. Runs entirely on REFERENCECLK.
//
//                LOCK is masked while PLL_RESETB is low, so the synchroniser
//                always starts flushed when an attempt begins. With LOCK
//                already high, SYS_RESET therefore falls exactly
//                SYNC_STAGES+STABLE_CYCLES cycles after the edge on which
//                PLL_RESETB rises (entry-cycle offset +0).
//
//                Optional build macro PLL_SUPERVISOR_BYPASS_FALLBACK_EN:
//                exhausting the retries enters BYPASS_RUN (PLL bypassed,
//                downstream released on the reference clock) instead of
//                FAULT. Without it PLL_BYPASS is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int LOSS_CNT_W    = 8
) (
    input  logic                             REFERENCECLK,
    input  logic                             RESET,
    input  logic                             LOCK,
    input  logic                             RETRY_REQ,
    output logic                             PLL_RESETB,
    output logic                             PLL_BYPASS,
    output logic                             SYS_RESET,
    output logic                             FAULT,
    output logic [STATE_W-1:0]               STATE,
    output logic [$clog2(MAX_RETRIES+1)-1:0] RETRY_COUNT,
    output logic [LOSS_CNT_W-1:0]            LOSS_COUNT
);

    localparam int c_rc_w   = $clog2(MAX_RETRIES + 1);
    localparam int c_tw     = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);

    localparam logic [c_tw-1:0]   c_rst_last  = c_tw'(RST_CYCLES - 1);
    localparam logic [c_tw-1:0]   c_to_last   = c_tw'(LOCK_TIMEOUT - 1);
    localparam logic [c_tw-1:0]   c_stab_last = c_tw'(STABLE_CYCLES - 1);
    localparam logic [c_tw-1:0]   c_tmr_one   = c_tw'(1);
    localparam logic [c_rc_w-1:0] c_retry_max = c_rc_w'(MAX_RETRIES);

`ifdef PLL_SUPERVISOR_BYPASS_FALLBACK_EN
    localparam state_t c_fail_state = c_st_bypass_run;
`else
    localparam state_t c_fail_state = c_st_fault;
`endif

    state_t                r_state;
    logic [c_tw-1:0]       r_timer;
    logic [c_rc_w-1:0]     r_retry;
    logic [LOSS_CNT_W-1:0] r_loss;
    logic                  r_pll_resetb;
    logic                  r_sys_reset;
    logic                  r_fault;

    state_t                w_nxt_state;
    logic [c_tw-1:0]       w_nxt_timer;
    logic [c_rc_w-1:0]     w_nxt_retry;
    logic [c_rc_w-1:0]     w_retry_inc;
    logic                  w_loss_evt;
    logic                  w_nxt_resetb;
    logic                  w_nxt_sys_reset;
    logic                  w_nxt_fault;
    logic                  w_lock_gated;
    logic                  w_lock_s;

    // A PLL held in reset cannot be locked; ignore LOCK until RESETB is high.
    assign w_lock_gated = LOCK & r_pll_resetb;

    pll_sup_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (REFERENCECLK),
        .rst (RESET),
        .i_d (w_lock_gated),
        .o_q (w_lock_s)
    );

    assign w_retry_inc = r_retry + 1'b1;

    // Next-state, phase timer and retry bookkeeping.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_timer = r_timer;
        w_nxt_retry = r_retry;
        w_loss_evt  = 1'b0;
        case (r_state)
            c_st_pll_rst: begin
                if (r_timer == c_rst_last) begin
                    w_nxt_state = c_st_wait_lock;
                    w_nxt_timer = '0;
                end else begin
                    w_nxt_timer = r_timer + 1'b1;
                end
            end
            c_st_wait_lock: begin
                // Lock wins over a coincident timeout; this cycle is the
                // first of the stable run.
                if (w_lock_s) begin
                    if (c_stab_last == '0) begin
                        w_nxt_state = c_st_run;
                        w_nxt_timer = '0;
                        w_nxt_retry = '0;
                    end else begin
                        w_nxt_state = c_st_stable;
                        w_nxt_timer = c_tmr_one;
                    end
                end else if (r_timer == c_to_last) begin
                    w_nxt_timer = '0;
                    w_nxt_retry = w_retry_inc;
                    w_nxt_state = (w_retry_inc == c_retry_max) ? c_fail_state : c_st_pll_rst;
                end else begin
                    w_nxt_timer = r_timer + 1'b1;
                end
            end
            c_st_stable: begin
                if (!w_lock_s) begin
                    w_nxt_state = c_st_wait_lock;
                    w_nxt_timer = '0;
                end else if (r_timer == c_stab_last) begin
                    w_nxt_state = c_st_run;
                    w_nxt_timer = '0;
                    w_nxt_retry = '0;
                end else begin
                    w_nxt_timer = r_timer + 1'b1;
                end
            end
            c_st_run: begin
                if (!w_lock_s) begin
                    w_nxt_state = c_st_pll_rst;
                    w_nxt_timer = '0;
                    w_loss_evt  = 1'b1;
                end
            end
            c_st_fault: begin
                if (RETRY_REQ) begin
                    w_nxt_state = c_st_pll_rst;
                    w_nxt_timer = '0;
                    w_nxt_retry = '0;
                end
            end
`ifdef PLL_SUPERVISOR_BYPASS_FALLBACK_EN
            c_st_bypass_run: begin
                if (RETRY_REQ) begin
                    w_nxt_state = c_st_pll_rst;
                    w_nxt_timer = '0;
                    w_nxt_retry = '0;
                end
            end
`endif
            default: begin
                w_nxt_state = c_st_pll_rst;
                w_nxt_timer = '0;
            end
        endcase
    end

    // Output levels are decoded from the next state so they register on the
    // same edge as the state change.
    always_comb begin
        w_nxt_resetb = (w_nxt_state == c_st_wait_lock) ||
                       (w_nxt_state == c_st_stable)    ||
                       (w_nxt_state == c_st_run);
`ifdef PLL_SUPERVISOR_BYPASS_FALLBACK_EN
        w_nxt_sys_reset = !((w_nxt_state == c_st_run) || (w_nxt_state == c_st_bypass_run));
        w_nxt_fault     = (w_nxt_state == c_st_fault) || (w_nxt_state == c_st_bypass_run);
`else
        w_nxt_sys_reset = (w_nxt_state != c_st_run);
        w_nxt_fault     = (w_nxt_state == c_st_fault);
`endif
    end

    // State, counters and registered outputs.
    always_ff @(posedge REFERENCECLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= c_st_pll_rst;
            r_timer      <= '0;
            r_retry      <= '0;
            r_loss       <= '0;
            r_pll_resetb <= 1'b0;
            r_sys_reset  <= 1'b1;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_timer      <= w_nxt_timer;
            r_retry      <= w_nxt_retry;
            r_pll_resetb <= w_nxt_resetb;
            r_sys_reset  <= w_nxt_sys_reset;
            r_fault      <= w_nxt_fault;
            if (w_loss_evt && (r_loss != '1)) begin
                r_loss <= r_loss + 1'b1;
            end
        end
    end

`ifdef PLL_SUPERVISOR_BYPASS_FALLBACK_EN
    logic r_pll_bypass;

    // Bypass follows the BYPASS_RUN state, registered with it.
    always_ff @(posedge REFERENCECLK or posedge RESET) begin
        if (RESET) begin
            r_pll_bypass <= 1'b0;
        end else begin
            r_pll_bypass <= (w_nxt_state == c_st_bypass_run);
        end
    end

    assign PLL_BYPASS = r_pll_bypass;
`else
    assign PLL_BYPASS = 1'b0;
`endif

    assign PLL_RESETB  = r_pll_resetb;
    assign SYS_RESET   = r_sys_reset;
    assign FAULT       = r_fault;
    assign STATE       = r_state;
    assign RETRY_COUNT = r_retry;
    assign LOSS_COUNT  = r_loss;

endmodule
`default_nettype wire

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Parametrised supervisor wrapped around an SB_PLL40_CORE-style PLL instance.
- Sequences the PLL's active-low reset and filters the asynchronous LOCK output through a synchroniser and a stability timer.
- Times out on a PLL that never locks and retries a bounded number of times; detects loss of lock in service.
- Drives the system reset request for all logic clocked from the PLL output; counts lock losses for debug readout.
- Runs entirely on the PLL reference clock and sits between the board oscillator input and the PLL wrapper in the top level.

Parameters:
- RST_CYCLES, 16: cycles PLL_RESETB is held low per attempt (min 1).
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before the attempt fails (min 1).
- STABLE_CYCLES, 256: consecutive synchronised-lock cycles required before RUN (min 1).
- MAX_RETRIES, 3: failed attempts tolerated before FAULT (min 1).
- SYNC_STAGES, 2: LOCK synchroniser depth (min 2).
- LOSS_CNT_W, 8: width of the lock-loss counter.

Ports:
- REFERENCECLK  in  1  reference clock; the only clock.
- RESET  in  1  asynchronous reset, active-high.
- LOCK  in  1  raw PLL lock, asynchronous to REFERENCECLK.
- RETRY_REQ  in  1  single-cycle pulse; leaves FAULT.
- PLL_RESETB  out  1  to PLL RESETB, active-low.
- PLL_BYPASS  out  1  to PLL BYPASS.
- SYS_RESET  out  1  active-high reset request for the PLL-clock domain.
- FAULT  out  1  high while in FAULT.
- STATE  out  3  current state encoding.
- RETRY_COUNT  out  $clog2(MAX_RETRIES+1)  failed attempts since the last RUN.
- LOSS_COUNT  out  LOSS_CNT_W  saturating count of lock losses while in RUN.

Behaviour:
- Reset values (RESET high): state=PLL_RST, PLL_RESETB=0, PLL_BYPASS=0, SYS_RESET=1, FAULT=0, RETRY_COUNT=0, LOSS_COUNT=0, all timers 0, synchroniser flops 0.
- lock_s: LOCK after SYNC_STAGES flops. All decisions use lock_s only.
- All outputs are registered.
- PLL_RST (0):
  - PLL_RESETB=0, SYS_RESET=1.
  - After RST_CYCLES cycles in this state, go to WAIT_LOCK; PLL_RESETB reads 1 from that edge.
- WAIT_LOCK (1):
  - Timer counts up each cycle.
  - lock_s=1: go to STABLE with the stability counter at 1.
  - Timer reaches LOCK_TIMEOUT with lock_s=0: this is a failed attempt.
  - If lock_s=1 on the timeout cycle, lock wins.
- STABLE (2):
  - Counter increments while lock_s=1.
  - lock_s=0: return to WAIT_LOCK, timer cleared, no retry charged.
  - Counter reaches STABLE_CYCLES: go to RUN.
- RUN (3):
  - On entry: SYS_RESET=0 and RETRY_COUNT cleared.
  - lock_s=0 for one cycle:
    - LOSS_COUNT increments, saturating at all-ones.
    - SYS_RESET=1 on the next edge.
    - Go to PLL_RST. No retry is charged.
- Failed attempt:
  - RETRY_COUNT increments.
  - If the new value equals MAX_RETRIES, go to FAULT; otherwise go to PLL_RST.
- FAULT (4):
  - PLL_RESETB=0, SYS_RESET=1, FAULT=1.
  - RETRY_REQ=1: clear RETRY_COUNT and go to PLL_RST.
  - RETRY_REQ is ignored in all other states.
- Latency: with LOCK already high on entry to WAIT_LOCK, SYS_RESET falls SYNC_STAGES+STABLE_CYCLES cycles later (±1 for the entry cycle, fixed by the implementation and documented in the RTL header).
- Mid-operation RESET forces the reset values immediately (asynchronous assertion), including LOSS_COUNT.
- Unused STATE encodings go to PLL_RST.

Optional Feature:
- Macro: PLL_SUPERVISOR_BYPASS_FALLBACK_EN.
- Defined:
  - Reaching MAX_RETRIES enters BYPASS_RUN (5) instead of FAULT.
  - In BYPASS_RUN: PLL_BYPASS=1, PLL_RESETB=0, SYS_RESET=0, FAULT=1. Downstream runs on the reference clock passed through the PLL.
  - RETRY_REQ in BYPASS_RUN: PLL_BYPASS=0, SYS_RESET=1 on the same edge, go to PLL_RST.
- Not defined: state 5 does not exist and PLL_BYPASS is tied 0.

Decomposition:
- Package pll_sup_pkg holds:
  - state typedef with encodings PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4, BYPASS_RUN=5;
  - STATE_W=3.
- Sub-module pll_sup_sync: N-stage single-bit synchroniser with asynchronous active-high reset to 0, parameter STAGES. Reused elsewhere in the codebase.

Test Plan:
- Defaults; release RESET; LOCK tied 1 → PLL_RESETB rises after 16 cycles; SYS_RESET falls 2+256 (±1) cycles later; STATE=3; RETRY_COUNT=0.
- LOCK tied 0 → three 16+4096-cycle attempts; RETRY_COUNT goes 1,2,3; FAULT=1; PLL_RESETB=0; SYS_RESET stays 1. Then RETRY_REQ pulse with LOCK=1 → reaches RUN; RETRY_COUNT=0.
- LOCK glitch: high 100 cycles, low 1 cycle, then high → returns to WAIT_LOCK; RETRY_COUNT unchanged; RUN entered 256 cycles after the second rise (+sync).
- In RUN, drop LOCK 1 cycle → SYS_RESET=1 within SYNC_STAGES+1 cycles; LOSS_COUNT=1; full resequence. Repeat 300 times with LOSS_CNT_W=8 → LOSS_COUNT saturates at 255.
- Assert RESET during STABLE at counter 200 → all outputs at reset values the same cycle; counters 0.
- With PLL_SUPERVISOR_BYPASS_FALLBACK_EN and LOCK=0 → after 3 failed attempts PLL_BYPASS=1, SYS_RESET=0, FAULT=1, STATE=5. Then RETRY_REQ → PLL_BYPASS=0 and SYS_RESET=1 on the same edge.
